// File: rtl/adder_selftest_if.sv
// Bus between the adder self-test block and its environment.
// Carries the operand/sum path to the adder plus run control and result status.
// master = self-test block, slave = adder side / controller.
interface adder_selftest_if;
  logic       ena;
  logic       start;
  logic [7:0] sum_in;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic       fail_valid;
  logic [7:0] first_fail_idx;

  modport master (
    input  ena, start, sum_in,
    output op_a, op_b, busy, done, pass, err_count, fail_valid, first_fail_idx
  );

  modport slave (
    output ena, start, sum_in,
    input  op_a, op_b, busy, done, pass, err_count, fail_valid, first_fail_idx
  );
endinterface

// File: rtl/adder_selftest.sv
// On-chip stimulus generator and checker for an 8-bit wrap-around adder.
// Latency: one vector every LATENCY+1 enabled cycles; done after NUM_VECTORS vectors.
// Backpressure: none; ena low freezes every register (clean pause, no sampling).
module adder_selftest #(
  parameter int NUM_VECTORS = 64,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_selftest_if.master  bus
);

  localparam int         WW       = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      idx;
  logic [15:0]     lfsr;
  logic [WW-1:0]   wait_cnt;
  logic [7:0]      op_a_q;
  logic [7:0]      op_b_q;
  logic [7:0]      err_q;
  logic [7:0]      ffi_q;
  logic            fv_q;
  logic            pass_q;

  // Control strobes and state-derived status
  logic            launch;
  logic            sample;
  logic            last;
  logic            mismatch;
  logic            busy;
  logic            done;

  // Datapath helpers
  logic [7:0]      sum_exp;
  logic [7:0]      err_nxt;
  logic [7:0]      nv_idx;
  logic            use_lfsr;
  logic [15:0]     nv;
  logic [15:0]     lfsr_step;

  // Directed vectors for idx 0..4, packed as {op_a, op_b}.
  function automatic logic [15:0] directed_vec(input logic [2:0] i);
    case (i)
      3'd1:    return {8'd10,  8'd15};
      3'd2:    return {8'd20,  8'd30};
      3'd3:    return {8'd255, 8'd1};
      3'd4:    return {8'd128, 8'd128};
      default: return 16'h0000;
    endcase
  endfunction

  // FSM state register; next-state logic already folds in ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state: launch from IDLE/DONE, finish on the last sample.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (launch)          state_next = RUN;
      RUN:        if (sample && last)  state_next = DONE;
      default:                         state_next = IDLE;
    endcase
  end

  // FSM outputs: strobes for the datapath and the status flags.
  always_comb begin
    launch   = bus.ena && bus.start && (state != RUN);
    sample   = bus.ena && (state == RUN) && (wait_cnt == '0);
    last     = (idx == LAST_IDX);
    mismatch = sample && (bus.sum_in != sum_exp);
    busy     = (state == RUN);
    done     = (state == DONE);
  end

  // Expected sum, saturating error count and next-vector selection.
  always_comb begin
    sum_exp   = op_a_q + op_b_q;
    err_nxt   = err_q;
    if (mismatch && (err_q != 8'hFF)) err_nxt = err_q + 8'd1;
    nv_idx    = launch ? 8'd0 : (idx + 8'd1);
    use_lfsr  = (nv_idx >= 8'd5);
    nv        = use_lfsr ? {lfsr[7:0], lfsr[15:8]} : directed_vec(nv_idx[2:0]);
    lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Run datapath: vector drive, latency wait, sampling and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= 8'd0;
      lfsr     <= 16'hACE1;
      wait_cnt <= '0;
      op_a_q   <= 8'd0;
      op_b_q   <= 8'd0;
      err_q    <= 8'd0;
      ffi_q    <= 8'd0;
      fv_q     <= 1'b0;
      pass_q   <= 1'b0;
    end else if (launch) begin
      idx      <= 8'd0;
      lfsr     <= 16'hACE1;
      wait_cnt <= WW'(LATENCY);
      op_a_q   <= nv[15:8];
      op_b_q   <= nv[7:0];
      err_q    <= 8'd0;
      ffi_q    <= 8'd0;
      fv_q     <= 1'b0;
      pass_q   <= 1'b0;
    end else if (sample) begin
      err_q <= err_nxt;
      if (mismatch && !fv_q) begin
        ffi_q <= idx;
        fv_q  <= 1'b1;
      end
      if (last) begin
        // Operands hold their last values; pass includes this sample.
        pass_q <= (err_nxt == 8'd0);
      end else begin
        idx      <= nv_idx;
        op_a_q   <= nv[15:8];
        op_b_q   <= nv[7:0];
        wait_cnt <= WW'(LATENCY);
        if (use_lfsr) lfsr <= lfsr_step;
      end
    end else if (bus.ena && (state == RUN) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - WW'(1);
    end
  end

  // Drive the interface outputs.
  always_comb begin
    bus.op_a           = op_a_q;
    bus.op_b           = op_b_q;
    bus.busy           = busy;
    bus.done           = done;
    bus.pass           = pass_q;
    bus.err_count      = err_q;
    bus.fail_valid     = fv_q;
    bus.first_fail_idx = ffi_q;
  end

endmodule

// File: doc/adder_selftest.md
Name: adder_selftest

Overview:
- Synthesizable on-chip stimulus generator and checker for the 8-bit wrap-around adder, `tt_um_adder`.
- Drives operand pairs onto the adder's operand inputs and samples the adder's sum output after a fixed latency.
- Compares each sample against the expected value (a+b) mod 256 and reports pass/fail with error count and first failing index.
- Gives silicon a self-test path without an external tester; sits beside the adder inside the user project wrapper.

Parameters:
- NUM_VECTORS, 64, total vectors per run; legal range 5..256.
- LATENCY, 1, clock edges between the operand-drive edge and sum-valid; 0 means the adder is combinational.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; when low, all state holds
- start  input  1  level-sampled run request
- sum_in  input  8  adder result under test
- op_a  output  8  operand A to adder, registered
- op_b  output  8  operand B to adder, registered
- busy  output  1  run in progress
- done  output  1  run complete; sticky until next start
- pass  output  1  valid when done; 1 iff err_count==0
- err_count  output  8  mismatches this run; saturates at 255
- fail_valid  output  1  at least one mismatch recorded
- first_fail_idx  output  8  vector index of the first mismatch

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; idx=0; lfsr=16'hACE1; wait counter=0.
- ena=0: every register holds, including the FSM, counters and LFSR. It acts as a clean pause and no sample is taken.
- States: IDLE, RUN, DONE.
- IDLE/DONE -> RUN on a clock edge with start=1 and ena=1. That edge:
  - clears err_count, fail_valid, first_fail_idx, done and pass;
  - sets idx=0, busy=1, lfsr=16'hACE1;
  - drives vector 0 onto op_a/op_b and loads the wait counter with LATENCY.
- start is ignored while in RUN.
- RUN, per-vector period = LATENCY+1 cycles:
  - The wait counter decrements each enabled edge while nonzero.
  - On the enabled edge where the counter is 0, sum_in is sampled and compared to op_a+op_b truncated to 8 bits.
- On mismatch:
  - err_count increments, saturating at 255;
  - if fail_valid=0, first_fail_idx<=idx and fail_valid<=1.
- On the same sample edge:
  - if idx==NUM_VECTORS-1: go to DONE with busy<=0, done<=1, pass<=(final err_count==0). The final count includes this sample. op_a/op_b hold their last values.
  - else: idx<=idx+1, the next vector is driven, and the counter is reloaded with LATENCY.
- Vector table:
  - idx 0..4 directed: (0,0), (10,15), (20,30), (255,1), (128,128). Expected sums 0, 25, 50, 0, 0.
  - idx>=5: op_a=lfsr[7:0], op_b=lfsr[15:8] of the current LFSR value. The LFSR advances once after each pseudo-random vector is driven.
  - LFSR is a 16-bit Fibonacci register, taps 16,14,13,11; shift left; feedback into bit 0.
- Timing: with start sampled at edge E0, sample k occurs at edge E0+(k+1)(LATENCY+1). done rises at edge E0+NUM_VECTORS*(LATENCY+1).
- Arithmetic: expected = 9-bit sum with the carry discarded. No overflow flag.
- Reset mid-run: immediate return to reset values with no partial report.

Test Plan:
1. Ideal registered adder (LATENCY=1), NUM_VECTORS=64, start pulse at edge 0 -> busy high for edges 1..128; done=1, pass=1, err_count=0, fail_valid=0 after edge 128; op_a/op_b observed 0/0, 10/15, 20/30, 255/1, 128/128 for idx 0..4.
2. Faulty adder returning a+b+1 only when a==255 -> idx 3 mismatches: err_count=1, first_fail_idx=3, fail_valid=1, pass=0.
3. Adder with sum bit 0 stuck at 1 -> directed vectors 0, 1, 2, 3, 4 all compared against 0, 25, 50, 0, 0: mismatches at idx 0, 2, 3, 4; first_fail_idx=0; err_count equals the bench model's count; pass=0.
4. ena toggled low for 10 cycles at random points during a run -> identical err_count/pass; done delayed by exactly the number of disabled cycles.
5. rst_n asserted at cycle 40 of a run -> all outputs 0 immediately (asynchronous); a fresh start then yields done at edge +128 with results identical to scenario 1.
6. start held high through DONE, and LATENCY=0 with a combinational adder -> second run starts on the edge after done, counters clear, done after 64 cycles; a start pulse during RUN has no effect.
